// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, default baud constant
// and counter-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Half-bit period giving 115200 baud from a 50 MHz clock.
    localparam int unsigned UART_HALF_BIT_TICS_DEFAULT = 217;

    function automatic int unsigned uart_cnt_width(input int unsigned bit_tics);
        return (bit_tics < 2) ? 1 : $clog2(bit_tics);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge strobe.
// All flops reset to the idle (high) line level.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic rxd_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic rx_s_q;
    logic rx_p_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_p_q <= 1'b1;
        end else begin
            meta_q <= rxd_i;
            rx_s_q <= meta_q;
            rx_p_q <= rx_s_q;
        end
    end

    assign rx_s_o = rx_s_q;
    assign fall_o = rx_p_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// Parametrised UART receiver with mid-bit sampling and a valid/ready output.
// Define UART_RX_PARITY_EN to receive and check one parity bit after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned HALF_BIT_TICS = UART_HALF_BIT_TICS_DEFAULT,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned PARITY_ODD    = 0
) (
    input  logic                 clk50,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned BIT_TICS = 2 * HALF_BIT_TICS;
    localparam int unsigned CntW     = uart_cnt_width(BIT_TICS);
    localparam int unsigned IdxW     = $clog2(DATA_BITS + 1);

    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT_TICS - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(BIT_TICS - 1);
    localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk_i  (clk50),
        .rst_i  (rst),
        .rxd_i  (rxd),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 fe_pend_q, fe_pend_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 complete;

`ifdef UART_RX_PARITY_EN
    logic pe_pend_q, pe_pend_d;
    logic parity_err_q, parity_err_d;

    always_ff @(posedge clk50) begin
        if (rst) begin
            pe_pend_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            pe_pend_q    <= pe_pend_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = 1'(PARITY_ODD);
    assign parity_err        = 1'b0;
`endif

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            fe_pend_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            fe_pend_q   <= fe_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        fe_pend_d = fe_pend_q;
        complete  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_pend_d = pe_pend_q;
`endif

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        idx_d     = '0;
                        fe_pend_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        pe_pend_d = 1'b0;
`endif
                    end
                end
            end
            DATA: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == DataLast) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    pe_pend_d = (^{shift_q, rx_s}) != 1'(PARITY_ODD);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so a following start edge is never missed.
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    fe_pend_d = fe_pend_q | ~rx_s;
                    if (idx_q == StopLast) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (complete) begin
            if (!valid_q || ready) begin
                data_d      = shift_q;
                frame_err_d = fe_pend_d;
                valid_d     = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = pe_pend_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with HALF_BIT_TICS=4 (8 clocks per bit), 8 data bits, 1 stop bit.
module tb_uart_rx;

    localparam int unsigned BT = 8;

    logic       clk50 = 1'b0;
    logic       rst;
    logic       rxd;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    always #5 clk50 = ~clk50;

    uart_rx #(
        .DATA_BITS     (8),
        .HALF_BIT_TICS (4),
        .STOP_BITS     (1),
        .PARITY_ODD    (0)
    ) dut (
        .clk50      (clk50),
        .rst        (rst),
        .rxd        (rxd),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] acc_data[$];
    logic       acc_fe[$];
    logic       acc_pe[$];
    int         valid_cycles = 0;
    int         ov_cycles    = 0;
    int         ov_pulses    = 0;
    logic       ov_prev      = 1'b0;

`ifdef UART_RX_PARITY_EN
    logic par_bit = 1'b0;
`endif

    // Observer: logs accepted words and overrun activity, sampled mid-cycle.
    always @(negedge clk50) begin
        if (valid && ready) begin
            acc_data.push_back(data);
            acc_fe.push_back(frame_err);
            acc_pe.push_back(parity_err);
        end
        if (valid) valid_cycles <= valid_cycles + 1;
        if (overrun) ov_cycles <= ov_cycles + 1;
        if (overrun && !ov_prev) ov_pulses <= ov_pulses + 1;
        ov_prev <= overrun;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        tick(BT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`endif
        send_bit(stop);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rxd   = 1'b1;
        ready = 1'b1;
        tick(3);
        @(negedge clk50);
        tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got=%0h exp=0", data); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", valid); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
        tests_run++; if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL reset_pe got=%b exp=0", parity_err); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_ov got=%b exp=0", overrun); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tick(1);
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_basic();
        int n0 = acc_data.size();
        int v0 = valid_cycles;
        int o0 = ov_pulses;
        logic [7:0] got_d;
        logic got_fe, got_pe;
        send_frame(8'hA5, 1'b1);
        tick(16);
        got_d  = (acc_data.size() > n0) ? acc_data[n0] : 8'hxx;
        got_fe = (acc_fe.size() > n0) ? acc_fe[n0] : 1'bx;
        got_pe = (acc_pe.size() > n0) ? acc_pe[n0] : 1'bx;
        tests_run++; if (acc_data.size() !== n0 + 1) begin tests_failed++; $display("FAIL basic_count got=%0d exp=%0d", acc_data.size(), n0 + 1); end
        tests_run++; if (got_d !== 8'hA5) begin tests_failed++; $display("FAIL basic_data got=%0h exp=a5", got_d); end
        tests_run++; if (got_fe !== 1'b0) begin tests_failed++; $display("FAIL basic_fe got=%b exp=0", got_fe); end
        tests_run++; if (got_pe !== 1'b0) begin tests_failed++; $display("FAIL basic_pe got=%b exp=0", got_pe); end
        tests_run++; if (valid_cycles - v0 !== 1) begin tests_failed++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cycles - v0); end
        tests_run++; if (ov_pulses - o0 !== 0) begin tests_failed++; $display("FAIL basic_overrun got=%0d exp=0", ov_pulses - o0); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy got=%b exp=0", busy); end
    endtask

    task automatic test_glitch();
        int n0 = acc_data.size();
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
        tick(16);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
        tests_run++; if (acc_data.size() !== n0) begin tests_failed++; $display("FAIL glitch_no_word got=%0d exp=%0d", acc_data.size(), n0); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL glitch_valid got=%b exp=0", valid); end
    endtask

    task automatic test_frame_err();
        int n0 = acc_data.size();
        logic [7:0] got_d;
        logic got_fe;
        send_frame(8'h3C, 1'b0);
        tick(BT * 12);
        got_d  = (acc_data.size() > n0) ? acc_data[n0] : 8'hxx;
        got_fe = (acc_fe.size() > n0) ? acc_fe[n0] : 1'bx;
        tests_run++; if (acc_data.size() !== n0 + 1) begin tests_failed++; $display("FAIL ferr_count got=%0d exp=%0d", acc_data.size(), n0 + 1); end
        tests_run++; if (got_d !== 8'h3C) begin tests_failed++; $display("FAIL ferr_data got=%0h exp=3c", got_d); end
        tests_run++; if (got_fe !== 1'b1) begin tests_failed++; $display("FAIL ferr_flag got=%b exp=1", got_fe); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ferr_no_retrigger got=%b exp=0", busy); end
        rxd = 1'b1;
        tick(16);
    endtask

    task automatic test_overrun();
        int n0 = acc_data.size();
        int o0 = ov_pulses;
        int c0 = ov_cycles;
        logic [7:0] got_d;
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(8);
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid got=%b exp=1", valid); end
        tests_run++; if (data !== 8'h11) begin tests_failed++; $display("FAIL ovr_hold_data got=%0h exp=11", data); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL ovr_fe got=%b exp=0", frame_err); end
        tests_run++; if (ov_pulses - o0 !== 1) begin tests_failed++; $display("FAIL ovr_pulses got=%0d exp=1", ov_pulses - o0); end
        tests_run++; if (ov_cycles - c0 !== 1) begin tests_failed++; $display("FAIL ovr_width got=%0d exp=1", ov_cycles - c0); end
        ready = 1'b1;
        tick(2);
        got_d = (acc_data.size() > n0) ? acc_data[n0] : 8'hxx;
        tests_run++; if (got_d !== 8'h11) begin tests_failed++; $display("FAIL ovr_accept got=%0h exp=11", got_d); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_valid_clear got=%b exp=0", valid); end
    endtask

    task automatic test_back_to_back();
        int n0 = acc_data.size();
        int o0 = ov_pulses;
        logic [7:0] got0, got1;
        ready = 1'b1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(16);
        got0 = (acc_data.size() > n0) ? acc_data[n0] : 8'hxx;
        got1 = (acc_data.size() > n0 + 1) ? acc_data[n0+1] : 8'hxx;
        tests_run++; if (acc_data.size() !== n0 + 2) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=%0d", acc_data.size(), n0 + 2); end
        tests_run++; if (got0 !== 8'h11) begin tests_failed++; $display("FAIL b2b_first got=%0h exp=11", got0); end
        tests_run++; if (got1 !== 8'h22) begin tests_failed++; $display("FAIL b2b_second got=%0h exp=22", got1); end
        tests_run++; if (ov_pulses - o0 !== 0) begin tests_failed++; $display("FAIL b2b_overrun got=%0d exp=0", ov_pulses - o0); end
    endtask

    task automatic test_reset_mid();
        int n0 = acc_data.size();
        logic [7:0] got_d;
        logic got_fe;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk50);
        @(negedge clk50);
        tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_data got=%0h exp=0", data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid got=%b exp=0", valid); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL rstmid_fe got=%b exp=0", frame_err); end
        tick(1);
        rst = 1'b0;
        tick(BT * 10);
        tests_run++; if (acc_data.size() !== n0) begin tests_failed++; $display("FAIL rstmid_discard got=%0d exp=%0d", acc_data.size(), n0); end
        send_frame(8'h81, 1'b1);
        tick(16);
        got_d  = (acc_data.size() > n0) ? acc_data[n0] : 8'hxx;
        got_fe = (acc_fe.size() > n0) ? acc_fe[n0] : 1'bx;
        tests_run++; if (got_d !== 8'h81) begin tests_failed++; $display("FAIL rstmid_next_data got=%0h exp=81", got_d); end
        tests_run++; if (got_fe !== 1'b0) begin tests_failed++; $display("FAIL rstmid_next_fe got=%b exp=0", got_fe); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int n0 = acc_data.size();
        logic got_pe0, got_pe1;
        ready   = 1'b1;
        par_bit = 1'b0;
        send_frame(8'h07, 1'b1);
        tick(16);
        par_bit = 1'b1;
        send_frame(8'h07, 1'b1);
        tick(16);
        got_pe0 = (acc_pe.size() > n0) ? acc_pe[n0] : 1'bx;
        got_pe1 = (acc_pe.size() > n0 + 1) ? acc_pe[n0+1] : 1'bx;
        tests_run++; if (got_pe0 !== 1'b1) begin tests_failed++; $display("FAIL parity_bad got=%b exp=1", got_pe0); end
        tests_run++; if (got_pe1 !== 1'b0) begin tests_failed++; $display("FAIL parity_good got=%b exp=0", got_pe1); end
        par_bit = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
